// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants, colour type and fetch FSM
// state encoding.
package vga_pkg;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT_END   = 783;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned V_ACT_END   = 514;

    typedef logic [11:0] color12_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN
    } fetchState_t;

endpackage

// File: rtl/line_buffer_2bank.sv
// Two-bank scanline store: one write port, one registered read port.
// The read is unreset so the array maps onto block RAM.
module line_buffer_2bank
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 160,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic          wrBank,
    input  logic [AW-1:0] wrAddr,
    input  color12_t      wrData,
    input  logic          rdBank,
    input  logic [AW-1:0] rdAddr,
    output color12_t      rdData
);

    color12_t mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrBank][wrAddr] <= wrData;
        end
        rdData <= mem[rdBank][rdAddr];
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Prefetches framebuffer rows into a two-bank line buffer and emits
// 4x-scaled 12-bit colour with syncs delayed to match the 2-cycle pipeline.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int unsigned FB_W = 160,
    parameter int unsigned FB_H = 120
) (
    input  logic        clk25Mhz,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    output logic [14:0] fbAddr,
    output logic        fbRdEn,
    input  logic [11:0] fbData,
    output logic [3:0]  outRed,
    output logic [3:0]  outGreen,
    output logic [3:0]  outBlue,
    output logic        hSync,
    output logic        vSync
);

    localparam int unsigned XW = $clog2(FB_W);
    localparam int unsigned RW = $clog2(FB_H);
    // Last line that prefetches: first line of the second-to-last source row.
    localparam int unsigned V_LAST_TRIG = V_ACT_START + 4 * (FB_H - 2);

    logic [9:0]    hOff;
    logic [9:0]    vOff;
    logic          hActive;
    logic          vActive;
    logic [XW-1:0] px;
    logic [RW-1:0] dispRow;

    assign hOff    = hCount - 10'(H_ACT_START);
    assign vOff    = vCount - 10'(V_ACT_START);
    assign hActive = (hCount >= 10'(H_ACT_START)) && (hCount <= 10'(H_ACT_END));
    assign vActive = (vCount >= 10'(V_ACT_START)) && (vCount <= 10'(V_ACT_END));
    assign px      = XW'(hOff >> 2);
    assign dispRow = RW'(vOff >> 2);

    logic          trigRow0;
    logic          trigNext;
    logic          trigger;
    logic [RW-1:0] trigRow;

    assign trigRow0 = (hCount == '0) && (vCount == 10'(V_ACT_START - 1));
    assign trigNext = (hCount == '0) && (vCount >= 10'(V_ACT_START))
                   && (vCount <= 10'(V_LAST_TRIG)) && (vOff[1:0] == 2'b00);
    assign trigger  = trigRow0 || trigNext;
    assign trigRow  = trigRow0 ? '0 : dispRow + RW'(1);

    fetchState_t   state;
    fetchState_t   nextState;
    logic [RW-1:0] fetchRow;
    logic [RW-1:0] nextRow;
    logic [XW-1:0] fetchX;
    logic [XW-1:0] nextX;
    logic          setPrimed;

    always_ff @(posedge clk25Mhz) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetchRow <= '0;
            fetchX   <= '0;
        end else begin
            state    <= nextState;
            fetchRow <= nextRow;
            fetchX   <= nextX;
        end
    end

    always_comb begin
        nextState = state;
        nextRow   = fetchRow;
        nextX     = fetchX;
        fbRdEn    = 1'b0;
        fbAddr    = '0;
        setPrimed = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (trigger) begin
                    nextRow   = trigRow;
                    nextX     = '0;
                    nextState = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                fbRdEn = 1'b1;
                // row*160 as shift-add keeps the address path multiplier-free
                fbAddr = 15'({fetchRow, 7'b0}) + 15'({fetchRow, 5'b0}) + 15'(fetchX);
                if (fetchX == XW'(FB_W - 1)) begin
                    nextState = FETCH_DRAIN;
                end else begin
                    nextX = fetchX + XW'(1);
                end
            end
            FETCH_DRAIN: begin
                nextState = FETCH_IDLE;
                setPrimed = (fetchRow == '0);
            end
            default: nextState = FETCH_IDLE;
        endcase
    end

    logic          wrEn;
    logic          wrBank;
    logic [XW-1:0] wrAddr;
    logic          primed;

    always_ff @(posedge clk25Mhz) begin
        if (reset) begin
            wrEn   <= 1'b0;
            wrBank <= 1'b0;
            wrAddr <= '0;
            primed <= 1'b0;
        end else begin
            wrEn   <= (state == FETCH_RUN);
            wrBank <= fetchRow[0];
            wrAddr <= fetchX;
            if (setPrimed) begin
                primed <= 1'b1;
            end
        end
    end

    color12_t rdData;

    line_buffer_2bank #(.DEPTH(FB_W)) lineBuf (
        .clk    (clk25Mhz),
        .wrEn   (wrEn),
        .wrBank (wrBank),
        .wrAddr (wrAddr),
        .wrData (fbData),
        .rdBank (dispRow[0]),
        .rdAddr (hActive ? px : '0),
        .rdData (rdData)
    );

    logic     qual1;
    logic     hSync1;
    logic     vSync1;
    color12_t pixel;

    always_ff @(posedge clk25Mhz) begin
        if (reset) begin
            qual1  <= 1'b0;
            hSync1 <= 1'b0;
            vSync1 <= 1'b0;
            pixel  <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
        end else begin
            qual1  <= hActive && vActive && primed;
            hSync1 <= hSyncIn;
            vSync1 <= vSyncIn;
            pixel  <= qual1 ? rdData : '0;
            hSync  <= hSync1;
            vSync  <= vSync1;
        end
    end

    assign outRed   = pixel[11:8];
    assign outGreen = pixel[7:4];
    assign outBlue  = pixel[3:0];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: drives h/v counters line by line,
// queues expected fetch strobes and delayed colour/sync, monitor compares.
module tb_framebuffer_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSyncIn;
    logic        vSyncIn;
    logic [14:0] fbAddr;
    logic        fbRdEn;
    logic [11:0] fbData;
    logic [3:0]  outRed;
    logic [3:0]  outGreen;
    logic [3:0]  outBlue;
    logic        hSync;
    logic        vSync;

    framebuffer_scanout #(.FB_W(160), .FB_H(120)) dut (
        .clk25Mhz (clk),
        .reset    (reset),
        .hCount   (hCount),
        .vCount   (vCount),
        .hSyncIn  (hSyncIn),
        .vSyncIn  (vSyncIn),
        .fbAddr   (fbAddr),
        .fbRdEn   (fbRdEn),
        .fbData   (fbData),
        .outRed   (outRed),
        .outGreen (outGreen),
        .outBlue  (outBlue),
        .hSync    (hSync),
        .vSync    (vSync)
    );

    always #20 clk = ~clk;

    function automatic logic [11:0] memWord(input int a);
        logic [31:0] v;
        v = a;
        return (a == 0) ? 12'hF00 : v[11:0];
    endfunction

    // Framebuffer: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        fbData <= fbRdEn ? memWord(int'(fbAddr)) : 12'h5A5;
    end

    int unsigned cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        int unsigned due;
        logic        rdEn;
        logic [14:0] addr;
    } fetchExp_t;

    typedef struct {
        int unsigned due;
        logic [11:0] color;
        logic        hs;
        logic        vs;
    } pixExp_t;

    fetchExp_t fq[$];
    pixExp_t   pq[$];

    int vectors = 0;
    int miscompares = 0;

    int bankRow [2] = '{-1, -1};
    bit primedM = 1'b0;
    bit fActive = 1'b0;
    int fRow = 0;
    int fCnt = 0;

    task automatic doCycle(input int h, input int v, input bit rst);
        int unsigned cur;
        fetchExp_t fe;
        pixExp_t pe;
        @(posedge clk);
        #1;
        cur = cycleCnt;
        hCount  = 10'(h);
        vCount  = 10'(v);
        hSyncIn = (h < 96);
        vSyncIn = (v < 2);
        reset   = rst;

        fe.due  = cur;
        fe.rdEn = fActive;
        fe.addr = fActive ? 15'(fRow * 160 + fCnt) : 15'd0;
        fq.push_back(fe);

        if (rst) begin
            while (pq.size() > 0 && pq[pq.size()-1].due > cur) void'(pq.pop_back());
            pe.color = 12'h000; pe.hs = 1'b0; pe.vs = 1'b0;
            pe.due = cur + 1; pq.push_back(pe);
            pe.due = cur + 2; pq.push_back(pe);
            if (fActive) bankRow[fRow % 2] = -1;
            fActive = 1'b0;
            primedM = 1'b0;
        end else begin
            pe.due   = cur + 2;
            pe.hs    = (h < 96);
            pe.vs    = (v < 2);
            pe.color = 12'h000;
            if (primedM && h >= 144 && h <= 783 && v >= 35 && v <= 514)
                pe.color = memWord(bankRow[((v - 35) / 4) % 2] * 160 + (h - 144) / 4);
            pq.push_back(pe);

            if (fActive) begin
                if (fCnt == 159) begin
                    fActive = 1'b0;
                    bankRow[fRow % 2] = fRow;
                    if (fRow == 0) primedM = 1'b1;
                end else begin
                    fCnt++;
                end
            end else if (h == 0 && v == 34) begin
                fActive = 1'b1; fRow = 0; fCnt = 0;
            end else if (h == 0 && v >= 35 && v <= 507 && (v - 35) % 4 == 0) begin
                fActive = 1'b1; fRow = (v - 35) / 4 + 1; fCnt = 0;
            end
        end
    endtask

    task automatic runLine(input int v);
        for (int h = 0; h < 800; h++) doCycle(h, v, 1'b0);
    endtask

    always @(negedge clk) begin
        fetchExp_t fe;
        pixExp_t pe;
        logic [11:0] got;
        if (fq.size() > 0 && fq[0].due == cycleCnt) begin
            fe = fq.pop_front();
            vectors++;
            if (fbRdEn !== fe.rdEn || fbAddr !== fe.addr) begin
                miscompares++;
                $display("FAIL fetch cyc=%0d h=%0d v=%0d: got rdEn=%b addr=%0d, want rdEn=%b addr=%0d",
                         cycleCnt, hCount, vCount, fbRdEn, fbAddr, fe.rdEn, fe.addr);
            end
        end
        if (pq.size() > 0 && pq[0].due == cycleCnt) begin
            pe = pq.pop_front();
            got = {outRed, outGreen, outBlue};
            vectors++;
            if (got !== pe.color || hSync !== pe.hs || vSync !== pe.vs) begin
                miscompares++;
                $display("FAIL pixel cyc=%0d h=%0d v=%0d: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                         cycleCnt, hCount, vCount, got, hSync, vSync, pe.color, pe.hs, pe.vs);
            end
        end
    end

    initial begin
        reset = 1'b1; hCount = 10'd797; vCount = 10'd524; hSyncIn = 1'b0; vSyncIn = 1'b0;
        repeat (3) @(posedge clk);
        doCycle(798, 524, 1'b1);
        doCycle(799, 524, 1'b1);
        // Sync rise at frame start, then prefetch of row 0 and early rows.
        runLine(0);
        runLine(1);
        runLine(2);
        runLine(34);
        runLine(35);
        runLine(36);
        runLine(38);
        runLine(39);
        runLine(40);
        runLine(43);
        runLine(44);
        // Bottom of the frame: last prefetch, last row, blanking.
        runLine(507);
        runLine(511);
        runLine(514);
        runLine(515);
        runLine(524);
        // Reset in the middle of the row-0 fetch (x=80).
        for (int h = 0; h <= 80; h++) doCycle(h, 34, 1'b0);
        doCycle(81, 34, 1'b1);
        for (int h = 82; h < 800; h++) doCycle(h, 34, 1'b0);
        runLine(35);
        runLine(34);
        runLine(35);
        repeat (4) @(negedge clk);
        vectors++;
        if (pq.size() != 0 || fq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pixel/%0d fetch entries left, want 0/0", pq.size(), fq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
